iq_agc: RTL and testbench

Automatic gain control stage directly downstream of ddc. It scales the decimated complex baseband stream by a programmable gain, saturates to DATA_WIDTH, and measures mean post-gain power over a power-of-two window. A small FSM steps the gain toward a target power with hysteresis. There is no backpressure, matching the ddc output.

---
 rtl/iq_agc_pkg.sv | 23 ++
 rtl/iq_agc_if.sv | 11 +
 rtl/iq_agc_power_acc.sv | 65 ++++++
 rtl/iq_agc.sv | 170 +++++++++++++++++
 tb/tb_iq_agc.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_agc_pkg.sv
// Shared constants, FSM state type and window clamp helper for the IQ AGC.
package dsp_pkg;
    localparam int GAIN_FRAC      = 8;
    localparam int AGC_HYST_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        UPDATE  = 2'd2
    } agc_state_e;

    function automatic logic [3:0] clamp_win(input logic [3:0] w, input logic [3:0] w_max);
        logic [3:0] r;
        if (w < 4'd1) begin
            r = 4'd1;
        end else if (w > w_max) begin
            r = w_max;
        end else begin
            r = w;
        end
        return r;
    endfunction
endpackage

// File: rtl/iq_agc_if.sv
// Valid/data sample stream without backpressure, one lane per IQ component.
interface iq_agc_if #(
    parameter int IQ_NUM     = 2,
    parameter int DATA_WIDTH = 16
);
    logic                              tvalid;
    logic [IQ_NUM-1:0][DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata);
    modport slave  (input  tvalid, input  tdata);
endinterface

// File: rtl/iq_agc_power_acc.sv
// Windowed mean of I^2+Q^2 over 2^W samples; done_o flags the window's last sample.
module iq_power_acc
    import dsp_pkg::*;
#(
    parameter int IQ_NUM       = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int WIN_LOG2_MAX = 10
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              clear_i,
    input  logic                              valid_i,
    input  logic [IQ_NUM-1:0][DATA_WIDTH-1:0] data_i,
    input  logic [3:0]                        win_i,
    output logic                              done_o,
    output logic [2*DATA_WIDTH-1:0]           power_o,
    output logic                              power_valid_o
);
    localparam int SQW   = 2 * DATA_WIDTH;
    localparam int PWR_W = SQW + 1;
    localparam int ACC_W = PWR_W + WIN_LOG2_MAX;

    logic signed [DATA_WIDTH-1:0] i_s, q_s;
    logic signed [SQW-1:0]        i_sq_s, q_sq_s;
    logic [PWR_W-1:0]             p_s;
    logic [ACC_W-1:0]             acc_r, sum_s, mean_s;
    logic [WIN_LOG2_MAX-1:0]      cnt_r, last_cnt_s;
    logic [SQW-1:0]               mean_sat_s;

    assign i_s        = data_i[0];
    assign q_s        = data_i[1];
    assign i_sq_s     = SQW'(i_s) * SQW'(i_s);
    assign q_sq_s     = SQW'(q_s) * SQW'(q_s);
    assign p_s        = {1'b0, i_sq_s} + {1'b0, q_sq_s};
    assign sum_s      = acc_r + ACC_W'(p_s);
    assign mean_s     = sum_s >> win_i;
    assign mean_sat_s = (|mean_s[ACC_W-1:SQW]) ? {SQW{1'b1}} : mean_s[SQW-1:0];
    assign last_cnt_s = ~({WIN_LOG2_MAX{1'b1}} << win_i);
    assign done_o     = valid_i && !clear_i && (cnt_r == last_cnt_s);

    // Accumulate per valid sample; publish the mean and restart on the last sample.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_r         <= '0;
            cnt_r         <= '0;
            power_o       <= '0;
            power_valid_o <= 1'b0;
        end else begin
            power_valid_o <= done_o;
            if (clear_i) begin
                acc_r <= '0;
                cnt_r <= '0;
            end else if (valid_i) begin
                if (done_o) begin
                    acc_r   <= '0;
                    cnt_r   <= '0;
                    power_o <= mean_sat_s;
                end else begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_r + WIN_LOG2_MAX'(1);
                end
            end
        end
    end
endmodule

// File: rtl/iq_agc.sv
// IQ automatic gain control: two-stage gain/saturate datapath and a
// power-driven gain stepping loop with hysteresis.
module iq_agc
    import dsp_pkg::*;
#(
    parameter int IQ_NUM       = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int GAIN_WIDTH   = 16,
    parameter int WIN_LOG2_MAX = 10
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic [GAIN_WIDTH-1:0]   gain_init_i,
    input  logic [GAIN_WIDTH-1:0]   step_i,
    input  logic [2*DATA_WIDTH-1:0] target_i,
    input  logic [3:0]              win_log2_i,
    iq_agc_if.slave                 s_axis,
    iq_agc_if.master                m_axis,
    output logic [GAIN_WIDTH-1:0]   gain_o,
    output logic [2*DATA_WIDTH-1:0] power_o,
    output logic                    power_valid_o
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int CW = 2 * DATA_WIDTH + 2;

    agc_state_e                        state_r, state_s;
    logic [3:0]                        win_r, win_s;
    logic [GAIN_WIDTH-1:0]             gain_r, gain_s, dec_sat_s, inc_sat_s;
    logic [GAIN_WIDTH:0]               dec_s, inc_s;
    logic [IQ_NUM-1:0][PW-1:0]         prod_r;
    logic                              valid1_r;
    logic [IQ_NUM-1:0][DATA_WIDTH-1:0] sat_s;
    logic                              win_done_s, acc_clr_s;
    logic [CW-1:0]                     tgt_s, hi_s, lo_s, pwr_s;

    function automatic logic [DATA_WIDTH-1:0] shift_sat(input logic [PW-1:0] p);
        logic [PW-1:0]         sh;
        logic [DATA_WIDTH-1:0] r;
        sh = PW'($signed(p) >>> GAIN_FRAC);
        if ((&sh[PW-1:DATA_WIDTH-1]) || !(|sh[PW-1:DATA_WIDTH-1])) begin
            r = sh[DATA_WIDTH-1:0];
        end else if (sh[PW-1]) begin
            r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    assign gain_o    = gain_r;
    assign acc_clr_s = !en_i || !((state_r == MEASURE) || (state_r == UPDATE));
    assign tgt_s     = {2'b00, target_i};
    assign hi_s      = tgt_s + (tgt_s >> AGC_HYST_SHIFT);
    assign lo_s      = tgt_s - (tgt_s >> AGC_HYST_SHIFT);
    assign pwr_s     = {2'b00, power_o};
    assign dec_s     = {1'b0, gain_r} - {1'b0, step_i};
    assign inc_s     = {1'b0, gain_r} + {1'b0, step_i};
    // Gain never reaches zero on the way down and clips at all-ones on the way up.
    assign dec_sat_s = (dec_s[GAIN_WIDTH] || (dec_s[GAIN_WIDTH-1:0] == '0)) ?
                       GAIN_WIDTH'(1) : dec_s[GAIN_WIDTH-1:0];
    assign inc_sat_s = inc_s[GAIN_WIDTH] ? {GAIN_WIDTH{1'b1}} : inc_s[GAIN_WIDTH-1:0];

    // S1: full-precision product of each lane with the current unsigned gain.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prod_r   <= '0;
            valid1_r <= 1'b0;
        end else begin
            valid1_r <= s_axis.tvalid;
            if (s_axis.tvalid) begin
                for (int k = 0; k < IQ_NUM; k++) begin
                    prod_r[k] <= $signed(PW'($signed(s_axis.tdata[k]))) *
                                 $signed(PW'({1'b0, gain_r}));
                end
            end
        end
    end

    // Floor shift by the gain fraction and clip to the sample range.
    always_comb begin
        sat_s = '0;
        for (int k = 0; k < IQ_NUM; k++) begin
            sat_s[k] = shift_sat(prod_r[k]);
        end
    end

    // S2: output register, holding the last sample while not valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
        end else begin
            m_axis.tvalid <= valid1_r;
            if (valid1_r) begin
                m_axis.tdata <= sat_s;
            end
        end
    end

    iq_power_acc #(
        .IQ_NUM       (IQ_NUM),
        .DATA_WIDTH   (DATA_WIDTH),
        .WIN_LOG2_MAX (WIN_LOG2_MAX)
    ) u_power_acc (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .clear_i       (acc_clr_s),
        .valid_i       (m_axis.tvalid),
        .data_i        (m_axis.tdata),
        .win_i         (win_r),
        .done_o        (win_done_s),
        .power_o       (power_o),
        .power_valid_o (power_valid_o)
    );

    // Loop state, latched window size and gain registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
            win_r   <= 4'd1;
            gain_r  <= '0;
        end else begin
            state_r <= state_s;
            win_r   <= win_s;
            gain_r  <= gain_s;
        end
    end

    // Next-state and gain decision; disabling the loop forces manual gain at once.
    always_comb begin
        state_s = state_r;
        win_s   = win_r;
        gain_s  = gain_r;
        if (!en_i) begin
            state_s = IDLE;
            gain_s  = gain_init_i;
        end else begin
            case (state_r)
                IDLE: begin
                    gain_s  = gain_init_i;
                    win_s   = clamp_win(win_log2_i, 4'(WIN_LOG2_MAX));
                    state_s = MEASURE;
                end
                MEASURE: begin
                    if (win_done_s) begin
                        state_s = UPDATE;
                    end else begin
                        state_s = MEASURE;
                    end
                end
                UPDATE: begin
                    if (pwr_s > hi_s) begin
                        gain_s = dec_sat_s;
                    end else if (pwr_s < lo_s) begin
                        gain_s = inc_sat_s;
                    end else begin
                        gain_s = gain_r;
                    end
                    win_s   = clamp_win(win_log2_i, 4'(WIN_LOG2_MAX));
                    state_s = MEASURE;
                end
                default: begin
                    state_s = IDLE;
                    gain_s  = gain_init_i;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iq_agc.sv
// Directed scoreboard bench for iq_agc: datapath, window power and gain loop.
module tb_iq_agc;
    localparam int DW = 16;
    localparam int GW = 16;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } iq_t;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic            en_i;
    logic [GW-1:0]   gain_init_i;
    logic [GW-1:0]   step_i;
    logic [2*DW-1:0] target_i;
    logic [3:0]      win_log2_i;
    logic [GW-1:0]   gain_o;
    logic [2*DW-1:0] power_o;
    logic            power_valid_o;

    iq_agc_if #(.IQ_NUM(2), .DATA_WIDTH(DW)) s_if ();
    iq_agc_if #(.IQ_NUM(2), .DATA_WIDTH(DW)) m_if ();

    iq_agc #(
        .IQ_NUM(2), .DATA_WIDTH(DW), .GAIN_WIDTH(GW), .WIN_LOG2_MAX(10)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .en_i          (en_i),
        .gain_init_i   (gain_init_i),
        .step_i        (step_i),
        .target_i      (target_i),
        .win_log2_i    (win_log2_i),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .gain_o        (gain_o),
        .power_o       (power_o),
        .power_valid_o (power_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          pv_cnt  = 0;
    int          mg      = 256;
    iq_t         exp_q[$];
    logic [31:0] pwr_q[$];

    function automatic logic [DW-1:0] model_out(input int s, input int g);
        longint f;
        f = (longint'(s) * longint'(g)) >>> 8;
        if (f > 32767) f = 32767;
        else if (f < -32768) f = -32768;
        return f[DW-1:0];
    endfunction

    function automatic longint model_pow(input int i, input int q, input int g);
        longint oi, oq;
        oi = longint'($signed(model_out(i, g)));
        oq = longint'($signed(model_out(q, g)));
        return oi * oi + oq * oq;
    endfunction

    function automatic int model_agc(input int g, input longint pwr, input longint tgt, input int stp);
        longint th;
        th = tgt / 8;
        if (pwr > tgt + th) return (g - stp < 1) ? 1 : g - stp;
        if (pwr < tgt - th) return (g + stp > 65535) ? 65535 : g + stp;
        return g;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard pops at the falling edge, inputs change 1 ns after the rising edge.
    task automatic tick();
        iq_t e;
        @(negedge clk_i);
        if (rstn_i === 1'b1 && m_if.tvalid === 1'b1) begin
            check("tdata_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tdata_i", 64'(m_if.tdata[0]), 64'(e.i));
                check("tdata_q", 64'(m_if.tdata[1]), 64'(e.q));
            end
        end
        if (rstn_i === 1'b1 && power_valid_o === 1'b1) begin
            pv_cnt++;
            check("power_expected", 64'(pwr_q.size() > 0), 64'(1));
            if (pwr_q.size() > 0) check("power_o", 64'(power_o), 64'(pwr_q.pop_front()));
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int i, input int q);
        iq_t e;
        s_if.tvalid   = 1'b1;
        s_if.tdata[0] = 16'(i);
        s_if.tdata[1] = 16'(q);
        e.i = model_out(i, mg);
        e.q = model_out(q, mg);
        exp_q.push_back(e);
        tick();
    endtask

    task automatic send_n(input int n, input int i, input int q, input int wlog, input logic push);
        for (int k = 0; k < n; k++) send(i, q);
        if (push) pwr_q.push_back(32'((longint'(n) * model_pow(i, q, mg)) >> wlog));
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_pv(input int prev, input string tag);
        for (int n = 0; n < 100 && pv_cnt == prev; n++) tick();
        check(tag, 64'(pv_cnt != prev), 64'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, 64'(m_if.tvalid), 64'(0));
        check({tag, "_tdata"}, 64'(m_if.tdata), 64'(0));
        check({tag, "_gain"}, 64'(gain_o), 64'(0));
        check({tag, "_power"}, 64'(power_o), 64'(0));
        check({tag, "_pvalid"}, 64'(power_valid_o), 64'(0));
    endtask

    initial begin
        int pv0;
        rstn_i = 1'b0; en_i = 1'b0; gain_init_i = 16'h0100; step_i = 16'h0000;
        target_i = 32'd0; win_log2_i = 4'd4;
        s_if.tvalid = 1'b0; s_if.tdata = '0;
        #3;
        check_zero("reset");
        #9;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        check("gain_after_reset", 64'(gain_o), 64'h0100);

        // Unity gain and exact 2-cycle latency
        mg = 256;
        send(1000, -1000);
        s_if.tvalid = 1'b0;
        check("latency_1", 64'(m_if.tvalid), 64'(0));
        tick();
        check("latency_2", 64'(m_if.tvalid), 64'(1));
        check("unity_i", 64'(m_if.tdata[0]), 64'(16'd1000));
        tick(); tick();
        check("gain_unity", 64'(gain_o), 64'h0100);

        // Saturation, then floor rounding of a negative sample
        gain_init_i = 16'h0200; mg = 512;
        tick(); tick();
        send(20000, -20000);
        s_if.tvalid = 1'b0;
        tick(); tick(); tick();
        check("sat_pos", 64'(m_if.tdata[0]), 64'h7FFF);
        check("sat_neg", 64'(m_if.tdata[1]), 64'h8000);
        gain_init_i = 16'h0080; mg = 128;
        tick(); tick();
        send(-1, 0);
        s_if.tvalid = 1'b0;
        tick(); tick(); tick();
        check("floor_i", 64'(m_if.tdata[0]), 64'hFFFF);
        check("floor_q", 64'(m_if.tdata[1]), 64'h0000);

        // Power metric over three back-to-back 16-sample windows
        gain_init_i = 16'h0100; mg = 256;
        target_i = 32'd1_000_000; step_i = 16'h0010; en_i = 1'b1;
        tick(); tick(); tick();
        pv0 = pv_cnt;
        for (int w = 0; w < 3; w++) send_n(16, 1000, 0, 4, 1'b1);
        for (int n = 0; n < 50 && pv_cnt != pv0 + 3; n++) tick();
        check("metric_pulses", 64'(pv_cnt), 64'(pv0 + 3));
        check("metric_power", 64'(power_o), 64'd1_000_000);
        check("metric_gain", 64'(gain_o), 64'h0100);

        // Convergence toward 250000 in steps of 0x10
        target_i = 32'd250_000;
        for (int w = 0; w < 10; w++) begin
            longint pw;
            pw = model_pow(1000, 0, mg);
            pv0 = pv_cnt;
            send_n(16, 1000, 0, 4, 1'b1);
            wait_pv(pv0, "conv_pulse");
            mg = model_agc(mg, pw, 250_000, 16);
            check("conv_gain", 64'(gain_o), 64'(mg));
        end
        check("conv_final", 64'(gain_o), 64'h0080);

        // Ceiling, then floor at 1
        target_i = 32'hFFFF_FFFF; step_i = 16'hFFFF;
        pv0 = pv_cnt;
        send_n(16, 1000, 0, 4, 1'b1);
        wait_pv(pv0, "ceil_pulse");
        mg = 65535;
        check("gain_ceiling", 64'(gain_o), 64'hFFFF);
        target_i = 32'd0;
        for (int w = 0; w < 2; w++) begin
            pv0 = pv_cnt;
            send_n(16, 1000, 0, 4, 1'b1);
            wait_pv(pv0, "floor_pulse");
            mg = 1;
            check("gain_floor", 64'(gain_o), 64'h0001);
        end

        // Abort by en_i after 10 of 16 samples
        pv0 = pv_cnt;
        send_n(10, 1000, 0, 4, 1'b0);
        en_i = 1'b0;
        tick();
        mg = 256;
        check("abort_gain", 64'(gain_o), 64'h0100);
        for (int n = 0; n < 20; n++) tick();
        check("abort_no_pulse", 64'(pv_cnt), 64'(pv0));

        // Re-enable: full window, step 0 freezes the gain
        target_i = 32'd0; step_i = 16'h0000; en_i = 1'b1;
        tick(); tick();
        pv0 = pv_cnt;
        send_n(16, 1000, 0, 4, 1'b1);
        wait_pv(pv0, "reenable_pulse");
        check("reenable_power", 64'(power_o), 64'd1_000_000);
        check("freeze_gain", 64'(gain_o), 64'h0100);

        // Asynchronous reset mid-window
        send_n(8, 1000, 0, 4, 1'b0);
        #2;
        rstn_i = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        pwr_q.delete();
        tick(); tick();
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        check("gain_after_rerst", 64'(gain_o), 64'h0100);
        check("tvalid_after_rerst", 64'(m_if.tvalid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule
